// File: rtl/fft_rad2_sched.sv
// In-place radix-2 DIT stage scheduler: one butterfly read pair per cycle, write-back PIPE=1+BF_LAT cycles later.
// No backpressure: each stage drains fully before the next one reads, and start is honoured only when idle.
module fft_rad2_sched #(
  parameter int         N_LOG2 = 6,
  parameter int         BF_LAT = 2,
  parameter logic [3:0] CUT_ON = 4'd1,
  localparam int        SW     = $clog2(N_LOG2) + 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [N_LOG2-1:0] scale_mask,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic              bf_valid,
  output logic [N_LOG2-2:0] tw_idx,
  output logic [3:0]        cut,
  output logic [SW-1:0]     stage,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam int KW   = N_LOG2 - 1;
  localparam int PIPE = 1 + BF_LAT;
  localparam int CW   = $clog2(PIPE + 1);

  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST   = CW'(PIPE - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_LOG2-1:0] mask_q, mask_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              rd_en_q, rd_en_d;
  logic [N_LOG2-1:0] rd_a_q, rd_a_d;
  logic [N_LOG2-1:0] rd_b_q, rd_b_d;
  logic [KW-1:0]     iss_tw_q, iss_tw_d;
  logic [3:0]        iss_cut_q, iss_cut_d;

  logic              bf_valid_q, bf_valid_d;
  logic [KW-1:0]     tw_q, tw_d;
  logic [3:0]        cut_q, cut_d;

  logic              pipe_en_q [PIPE];
  logic              pipe_en_d [PIPE];
  logic [N_LOG2-1:0] pipe_a_q  [PIPE];
  logic [N_LOG2-1:0] pipe_a_d  [PIPE];
  logic [N_LOG2-1:0] pipe_b_q  [PIPE];
  logic [N_LOG2-1:0] pipe_b_d  [PIPE];

  logic [N_LOG2-1:0] iss_k, iss_half, iss_low, iss_j, iss_a;
  logic [KW-1:0]     iss_tw;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
          mask_d  = scale_mask;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        // Hold off the next stage until the last write-back of this one has landed.
        if (cnt_q == CNT_LAST) begin
          if (stage_q < STAGE_LAST) begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end else begin
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are computed from the next-cycle k/stage so the read strobe and operands are registered together.
  always_comb begin
    iss_k    = {1'b0, k_d};
    iss_half = N_LOG2'(1) << stage_d;
    iss_low  = iss_half - N_LOG2'(1);
    iss_j    = iss_k & iss_low;
    iss_a    = ((iss_k & ~iss_low) << 1) | iss_j;
    iss_tw   = KW'(iss_j) << (STAGE_LAST - stage_d);

    rd_en_d   = (state_d == RUN);
    rd_a_d    = rd_en_d ? iss_a : '0;
    rd_b_d    = rd_en_d ? (iss_a | iss_half) : '0;
    iss_tw_d  = rd_en_d ? iss_tw : '0;
    iss_cut_d = (rd_en_d && (|(mask_d & iss_half))) ? CUT_ON : 4'd0;

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == FIN);

    bf_valid_d = rd_en_q;
    tw_d       = iss_tw_q;
    cut_d      = iss_cut_q;
  end

  always_comb begin
    pipe_en_d[0] = rd_en_q;
    pipe_a_d[0]  = rd_a_q;
    pipe_b_d[0]  = rd_b_q;
    for (int i = 1; i < PIPE; i++) begin
      pipe_en_d[i] = pipe_en_q[i-1];
      pipe_a_d[i]  = pipe_a_q[i-1];
      pipe_b_d[i]  = pipe_b_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      k_q        <= '0;
      stage_q    <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      iss_tw_q   <= '0;
      iss_cut_q  <= '0;
      bf_valid_q <= 1'b0;
      tw_q       <= '0;
      cut_q      <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_en_q[i] <= 1'b0;
        pipe_a_q[i]  <= '0;
        pipe_b_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      stage_q    <= stage_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      iss_tw_q   <= iss_tw_d;
      iss_cut_q  <= iss_cut_d;
      bf_valid_q <= bf_valid_d;
      tw_q       <= tw_d;
      cut_q      <= cut_d;
      for (int i = 0; i < PIPE; i++) begin
        pipe_en_q[i] <= pipe_en_d[i];
        pipe_a_q[i]  <= pipe_a_d[i];
        pipe_b_q[i]  <= pipe_b_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign bf_valid  = bf_valid_q;
  assign tw_idx    = tw_q;
  assign cut       = cut_q;
  assign stage     = stage_q;
  assign wr_en     = pipe_en_q[PIPE-1];
  assign wr_addr_a = pipe_a_q[PIPE-1];
  assign wr_addr_b = pipe_b_q[PIPE-1];

endmodule

// File: tb/tb_fft_rad2_sched.sv
// Scoreboarded bench: an 8-point instance checked event by event, and a 64-point instance driving a butterfly/RAM model.
module tb_fft_rad2_sched;

  localparam int L3   = 3;
  localparam int L6   = 6;
  localparam int PIPE = 3;
  localparam int SW3  = $clog2(L3) + 1;
  localparam int SW6  = $clog2(L6) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic           aresetn3, start3, busy3, done3, rd_en3, bf_valid3, wr_en3;
  logic [L3-1:0]  mask3, rd_a3, rd_b3, wr_a3, wr_b3;
  logic [L3-2:0]  tw3;
  logic [3:0]     cut3;
  logic [SW3-1:0] stage3;

  logic           aresetn6, start6, busy6, done6, rd_en6, bf_valid6, wr_en6;
  logic [L6-1:0]  mask6, rd_a6, rd_b6, wr_a6, wr_b6;
  logic [L6-2:0]  tw6;
  logic [3:0]     cut6;
  logic [SW6-1:0] stage6;

  fft_rad2_sched #(.N_LOG2(L3), .BF_LAT(2), .CUT_ON(4'd1)) u_dut3 (
    .clk(clk), .aresetn(aresetn3), .start(start3), .scale_mask(mask3),
    .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr_a(rd_a3), .rd_addr_b(rd_b3),
    .bf_valid(bf_valid3), .tw_idx(tw3), .cut(cut3), .stage(stage3),
    .wr_en(wr_en3), .wr_addr_a(wr_a3), .wr_addr_b(wr_b3)
  );

  fft_rad2_sched #(.N_LOG2(L6), .BF_LAT(2), .CUT_ON(4'd1)) u_dut6 (
    .clk(clk), .aresetn(aresetn6), .start(start6), .scale_mask(mask6),
    .busy(busy6), .done(done6), .rd_en(rd_en6), .rd_addr_a(rd_a6), .rd_addr_b(rd_b6),
    .bf_valid(bf_valid6), .tw_idx(tw6), .cut(cut6), .stage(stage6),
    .wr_en(wr_en6), .wr_addr_a(wr_a6), .wr_addr_b(wr_b6)
  );

  typedef struct { int cyc; int s; int a; int b; } rw_t;
  typedef struct { int cyc; int tw; int cut; } bf_t;
  rw_t exp_rd[$];
  rw_t exp_wr[$];
  bf_t exp_bf[$];
  int  exp_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event at cycle %0d, none expected", name, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference schedule for the 8-point instance, straight from the butterfly index formulas.
  task automatic push_xform(input int c0, input int mask);
    int n2;
    n2 = 1 << (L3 - 1);
    for (int s = 0; s < L3; s++) begin
      for (int k = 0; k < n2; k++) begin
        int  half, j, grp, t;
        rw_t e;
        bf_t f;
        half  = 1 << s;
        j     = k % half;
        grp   = k / half;
        t     = c0 + 1 + s * (n2 + PIPE) + k;
        e.cyc = t;
        e.s   = s;
        e.a   = grp * 2 * half + j;
        e.b   = e.a + half;
        exp_rd.push_back(e);
        f.cyc = t + 1;
        f.tw  = j * (1 << (L3 - 1 - s));
        f.cut = ((mask >> s) & 1) != 0 ? 1 : 0;
        exp_bf.push_back(f);
        e.cyc = t + PIPE;
        exp_wr.push_back(e);
      end
    end
    exp_done.push_back(c0 + 1 + L3 * (n2 + PIPE));
  endtask

  task automatic purge_after(input int now);
    while (exp_rd.size() > 0 && exp_rd[exp_rd.size()-1].cyc > now) exp_rd.delete(exp_rd.size()-1);
    while (exp_wr.size() > 0 && exp_wr[exp_wr.size()-1].cyc > now) exp_wr.delete(exp_wr.size()-1);
    while (exp_bf.size() > 0 && exp_bf[exp_bf.size()-1].cyc > now) exp_bf.delete(exp_bf.size()-1);
    while (exp_done.size() > 0 && exp_done[exp_done.size()-1] > now) exp_done.delete(exp_done.size()-1);
  endtask

  task automatic go_start3(input logic [L3-1:0] m);
    mask3  = m;
    start3 = 1'b1;
    push_xform(cyc, int'(m));
    step(1);
    start3 = 1'b0;
  endtask

  task automatic wait_done3(input int budget);
    int n;
    n = 0;
    while (done3 !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check("done3_seen", done3, 1);
  endtask

  task automatic check_zero3();
    check("z_busy", busy3, 0);      check("z_done", done3, 0);
    check("z_rd_en", rd_en3, 0);    check("z_rd_a", rd_a3, 0);
    check("z_rd_b", rd_b3, 0);      check("z_bf_valid", bf_valid3, 0);
    check("z_tw", tw3, 0);          check("z_cut", cut3, 0);
    check("z_stage", stage3, 0);    check("z_wr_en", wr_en3, 0);
    check("z_wr_a", wr_a3, 0);      check("z_wr_b", wr_b3, 0);
  endtask

  always @(negedge clk) begin : mon3
    rw_t e;
    bf_t f;
    int  d;
    if (rd_en3 === 1'b1) begin
      if (exp_rd.size() == 0) unexpected("rd_extra");
      else begin
        e = exp_rd.pop_front();
        check("rd_cyc", cyc, e.cyc);
        check("rd_a", rd_a3, e.a);
        check("rd_b", rd_b3, e.b);
        check("rd_stage", stage3, e.s);
        check("rd_busy", busy3, 1);
      end
    end
    if (bf_valid3 === 1'b1) begin
      if (exp_bf.size() == 0) unexpected("bf_extra");
      else begin
        f = exp_bf.pop_front();
        check("bf_cyc", cyc, f.cyc);
        check("bf_tw", tw3, f.tw);
        check("bf_cut", cut3, f.cut);
      end
    end
    if (wr_en3 === 1'b1) begin
      if (exp_wr.size() == 0) unexpected("wr_extra");
      else begin
        e = exp_wr.pop_front();
        check("wr_cyc", cyc, e.cyc);
        check("wr_a", wr_a3, e.a);
        check("wr_b", wr_b3, e.b);
      end
    end
    if (rd_en3 === 1'b1 && wr_en3 === 1'b1)
      check("rw_same_addr", (rd_a3 == wr_a3 || rd_a3 == wr_b3 || rd_b3 == wr_a3 || rd_b3 == wr_b3), 0);
    if (done3 === 1'b1) begin
      if (exp_done.size() == 0) unexpected("done_extra");
      else begin
        d = exp_done.pop_front();
        check("done_cyc", cyc, d);
        check("done_busy", busy3, 0);
      end
    end
  end

  // 64-point path: RAM plus a butterfly whose C/D emerge PIPE cycles after the read.
  int mem_re [64];
  int mem_im [64];
  typedef struct { int ar; int ai; int br; int bi; } opnd_t;
  typedef struct { int cr; int ci; int dr; int di; } res_t;
  opnd_t opq[$];
  res_t  resq[$];

  always @(negedge clk) begin : mon6
    opnd_t o;
    res_t  r;
    real   th;
    int    wbr, wbi;
    if (wr_en6 === 1'b1) begin
      if (resq.size() == 0) unexpected("wr6_extra");
      else begin
        r = resq.pop_front();
        mem_re[wr_a6] = r.cr; mem_im[wr_a6] = r.ci;
        mem_re[wr_b6] = r.dr; mem_im[wr_b6] = r.di;
      end
    end
    if (bf_valid6 === 1'b1) begin
      if (opq.size() == 0) unexpected("bf6_extra");
      else begin
        o    = opq.pop_front();
        th   = 2.0 * 3.14159265358979 * real'(tw6) / 64.0;
        wbr  = int'(real'(o.br) * $cos(th) + real'(o.bi) * $sin(th));
        wbi  = int'(real'(o.bi) * $cos(th) - real'(o.br) * $sin(th));
        r.cr = (o.ar + wbr) >>> cut6;
        r.ci = (o.ai + wbi) >>> cut6;
        r.dr = (o.ar - wbr) >>> cut6;
        r.di = (o.ai - wbi) >>> cut6;
        resq.push_back(r);
      end
    end
    if (rd_en6 === 1'b1) begin
      o.ar = mem_re[rd_a6]; o.ai = mem_im[rd_a6];
      o.br = mem_re[rd_b6]; o.bi = mem_im[rd_b6];
      opq.push_back(o);
    end
  end

  task automatic impulse_run6();
    int c6, v, expv, n;
    logic [L6-1:0] m;
    m = L6'($urandom);
    v = int'($urandom_range(1, 127)) * 64;
    for (int i = 0; i < 64; i++) begin
      mem_re[i] = 0;
      mem_im[i] = 0;
    end
    mem_re[0] = v;
    mask6  = m;
    c6     = cyc;
    start6 = 1'b1;
    step(1);
    start6 = 1'b0;
    mask6  = ~m;
    n = 0;
    while (done6 !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    check("done6_seen", done6, 1);
    check("done6_cyc", cyc, c6 + 6 * (32 + 3) + 1);
    expv = v >> $countones(m);
    for (int i = 0; i < 64; i++) begin
      check("bin_re", mem_re[i], expv);
      check("bin_im", mem_im[i], 0);
    end
    check("bf6_left", opq.size() + resq.size(), 0);
    step(1);
  endtask

  initial begin
    aresetn3 = 1'b0; start3 = 1'b0; mask3 = '0;
    aresetn6 = 1'b0; start6 = 1'b0; mask6 = '0;
    step(2);
    check_zero3();
    aresetn3 = 1'b1;
    step(2);

    // Transform 1: mask 101, mask change and stray start mid-run.
    go_start3(3'b101);
    step(4);
    mask3 = L3'($urandom);
    step(5);
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    wait_done3(60);

    // Back-to-back start right after done.
    step(1);
    go_start3(L3'($urandom));
    wait_done3(60);

    // Abort with a one-cycle reset nine cycles in.
    step(1 + int'($urandom_range(0, 3)));
    go_start3(L3'($urandom));
    step(8);
    aresetn3 = 1'b0;
    purge_after(cyc);
    step(1);
    check_zero3();
    aresetn3 = 1'b1;
    step(30);

    for (int r = 0; r < 2; r++) begin
      step(int'($urandom_range(1, 4)));
      go_start3(L3'($urandom));
      wait_done3(60);
    end
    step(5);
    check("rd_left", exp_rd.size(), 0);
    check("bf_left", exp_bf.size(), 0);
    check("wr_left", exp_wr.size(), 0);
    check("done_left", exp_done.size(), 0);

    aresetn6 = 1'b1;
    step(2);
    impulse_run6();
    impulse_run6();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_rad2_sched.md
# fft_rad2_sched

In-place radix-2 decimation-in-time FFT stage scheduler. It sequences a single `butterfly_Rad2` instance (D_WIDTH 14, W_WIDTH 4) over an N-point dual-port sample buffer for log2(N) stages. Each cycle it issues one butterfly read pair, a twiddle index and a per-stage cut value, then returns the matching write-back pair after the pipeline delay. It sits between the register-file control bits (start, scale mask) and the sample RAM / twiddle ROM of the acquisition FFT path.

## Interface
- N_LOG2, 6, log2 of FFT length N; legal range 2..12
- BF_LAT, 2, butterfly latency in clk cycles from operands to C/D outputs
- CUT_ON, 4'd1, cut value driven in stages whose scale_mask bit is 1
- clk  in  1  single clock for the block
- aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- scale_mask  in  N_LOG2  bit s selects CUT_ON for stage s; sampled at start
- busy  out  1  high from first RUN cycle until done
- done  out  1  one-cycle pulse on completion
- rd_en  out  1  read strobe for both RAM ports
- rd_addr_a, rd_addr_b  out  N_LOG2  butterfly operand addresses A and B
- bf_valid  out  1  rd_en delayed 1 cycle (RAM data present at butterfly input)
- tw_idx  out  N_LOG2-1  twiddle ROM index, aligned with bf_valid
- cut  out  4  butterfly cut, aligned with bf_valid
- stage  out  ceil(log2(N_LOG2))+1  current stage index
- wr_en  out  1  write strobe for butterfly results
- wr_addr_a, wr_addr_b  out  N_LOG2  write-back addresses for C and D

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 latches scale_mask, clears stage and k, and enters RUN. start is ignored in every other state.
- RUN issues one butterfly per cycle, k = 0..N/2-1:
  - half = 1<<stage, j = k & (half-1), grp = k >> stage
  - rd_addr_a = grp*2*half + j; rd_addr_b = rd_addr_a + half
  - tw_idx = j << (N_LOG2-1-stage)
  - cut = scale_mask[stage] ? CUT_ON : 0
- After k = N/2-1, RUN → DRAIN.
- DRAIN lasts PIPE = 1+BF_LAT cycles, so every write of the stage lands before the next stage reads (in-place RAW hazard). On exit:
  - stage < N_LOG2-1 → increment stage, k=0, go to RUN
  - otherwise → FIN
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Write-back: wr_en, wr_addr_a, wr_addr_b are rd_en, rd_addr_a, rd_addr_b delayed by PIPE cycles through a shift register. The shift register is not gated by the FSM.
- Input ordering: the loader writes the buffer in bit-reversed order; output is in natural order. Reordering is outside this block.
- No overlap between stages or between transforms; a new start is accepted only back in IDLE.

## Timing
- Reset (aresetn=0, asynchronous):
  - FSM → IDLE
  - busy, done, rd_en, bf_valid, wr_en, the delay-line valid bits → 0
  - all addresses, tw_idx, cut, stage → 0
- Reset mid-transform aborts immediately. No pending wr_en may appear after release.
- Cycle 0: start sampled in IDLE.
  - Cycle 1: first rd_en=1, busy=1.
  - rd_en at cycle t → bf_valid, tw_idx, cut at t+1 → wr_en at t+PIPE.
- Per stage: N/2 issue cycles + PIPE drain cycles.
- Last wr_en falls at cycle N_LOG2*(N/2+PIPE). done pulses on the following cycle, and busy drops the same cycle.
- In the cycle after the last write of a stage, the first read of the next stage is issued. The RAM never sees a read and write to the same address in one cycle.

## Test plan
- N_LOG2=3, BF_LAT=2, start at cycle 0:
  - stage 0: rd A=0,2,4,6 / B=1,3,5,7, tw 0,0,0,0
  - stage 1: A=0,1,4,5 / B=2,3,6,7, tw 0,2,0,2
  - stage 2: A=0,1,2,3 / B=4,5,6,7, tw 0,1,2,3
  - rd_en at cycles 1-4, 8-11, 15-18; done at cycle 22
- Same config with a pipe-delay butterfly model: wr_addr_a/b equal rd_addr_a/b from 3 cycles earlier for all 12 butterflies. wr_en is never high in the same cycle as a read of the next stage.
- scale_mask=3'b101 → cut = 1 during stage 0 and stage 2 bf_valid cycles, 0 during stage 1. Change scale_mask mid-run → no effect.
- start pulsed at cycle 10 while busy → ignored: exactly 12 butterflies and one done. A start on the cycle after done begins a new transform.
- aresetn low at cycle 9 for 1 cycle → all outputs 0 at once, no wr_en after release. A subsequent start runs a full, correct transform.
- N_LOG2=6 with a functional butterfly and bit-reversed impulse at index 0: every output bin equals the impulse value scaled per scale_mask. done at cycle 6*(32+3)+1 = 211.
